datapath_histogram: RTL and testbench

//  Streaming frame-histogram stage for the 8-bit pixel datapath. It accumulates
//  a histogram of the incoming pixels over one frame of FRAME_LEN pixels. At end
//  of frame it streams the NUM_BINS bin counts downstream as an 8-bit packet,

---
 rtl/histogram_pkg.sv | 18 +
 rtl/hist_bin_array.sv | 45 ++++
 rtl/datapath_histogram.sv | 147 ++++++++++++++
 tb/tb_datapath_histogram.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// rtl/histogram_pkg.sv - shared types and helpers for the frame-histogram stage
package histogram_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int bin_idx_w(input int num_bins);
    return (num_bins > 1) ? $clog2(num_bins) : 1;
  endfunction

  function automatic logic [7:0] sat8(input logic [31:0] x);
    return (x > 32'd255) ? 8'hFF : x[7:0];
  endfunction

endpackage

// File: rtl/hist_bin_array.sv
// rtl/hist_bin_array.sv - histogram bin registers: clear-all, saturating increment, read port
module hist_bin_array #(
  parameter int NUM_BINS = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [IDX_W-1:0] inc_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bin_q [NUM_BINS];
  logic [CNT_W-1:0] bin_d [NUM_BINS];

  // Clear and increment on the same edge leaves the addressed bin at 1.
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      bin_d[b] = clr_i ? '0 : bin_q[b];
      if (inc_i && (inc_idx_i == IDX_W'(b)) && (bin_d[b] != CNT_MAX)) begin
        bin_d[b] = bin_d[b] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        bin_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BINS; b++) begin
        bin_q[b] <= bin_d[b];
      end
    end
  end

  assign rd_cnt_o = bin_q[rd_idx_i];

endmodule

// File: rtl/datapath_histogram.sv
// rtl/datapath_histogram.sv - per-frame pixel histogram, emitted as a packet of bin counts
module datapath_histogram
  import histogram_pkg::*;
#(
  parameter int FRAME_LEN = 24,
  parameter int NUM_BINS  = 8,
  parameter int CNT_W     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       sof_in,
  output logic       busy_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sof_out,
  input  logic       busy_in
);

  localparam int IDX_W = bin_idx_w(NUM_BINS);
  localparam int PIX_W = $clog2(FRAME_LEN + 1);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d, pix_next;
  logic [IDX_W-1:0] k_q, k_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic [7:0]       data_q, data_d;

  logic             bin_clr, bin_inc;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic [IDX_W-1:0] pix_idx;
  logic             accept;
  logic             unused_pix_bits;

  assign pix_idx         = data_in[7 -: IDX_W];
  assign unused_pix_bits = ^data_in;
  assign accept          = valid_in && !busy_q && (state_q == ACCUM);

  hist_bin_array #(
    .NUM_BINS (NUM_BINS),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_bins (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clr_i     (bin_clr),
    .inc_i     (bin_inc),
    .inc_idx_i (pix_idx),
    .rd_idx_i  (rd_idx),
    .rd_cnt_o  (rd_cnt)
  );

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    pix_next  = pix_cnt_q;
    k_d       = k_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    data_d    = data_q;
    bin_clr   = 1'b0;
    bin_inc   = 1'b0;
    rd_idx    = '0;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          // sof restarts the frame, discarding any partial histogram.
          bin_inc   = 1'b1;
          bin_clr   = sof_in;
          pix_next  = sof_in ? PIX_W'(1) : (pix_cnt_q + PIX_W'(1));
          pix_cnt_d = pix_next;
          if (pix_next == PIX_W'(FRAME_LEN)) begin
            state_d = FLUSH;
            busy_d  = 1'b1;
          end
        end
      end

      FLUSH: begin
        rd_idx  = '0;
        data_d  = sat8(32'(rd_cnt));
        valid_d = 1'b1;
        sof_d   = 1'b1;
        k_d     = '0;
        state_d = DRAIN;
      end

      DRAIN: begin
        if (valid_q && !busy_in) begin
          if (k_q == IDX_W'(NUM_BINS - 1)) begin
            valid_d   = 1'b0;
            sof_d     = 1'b0;
            data_d    = '0;
            bin_clr   = 1'b1;
            pix_cnt_d = '0;
            busy_d    = 1'b0;
            state_d   = ACCUM;
          end else begin
            k_d     = k_q + IDX_W'(1);
            rd_idx  = k_q + IDX_W'(1);
            data_d  = sat8(32'(rd_cnt));
            sof_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = ACCUM;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ACCUM;
      pix_cnt_q <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      data_q    <= data_d;
    end
  end

  assign busy_out  = busy_q;
  assign valid_out = valid_q;
  assign sof_out   = sof_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_datapath_histogram.sv
// tb/tb_datapath_histogram.sv - directed table-driven bench for datapath_histogram
module tb_datapath_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_in;
  logic       valid_in, sof_in, busy_in, sel;
  logic       busy1, valid1, sof1, busy2, valid2, sof2;
  logic [7:0] d1, d2;
  logic       v1_in, v2_in;
  logic       m_busy, m_valid, m_sof;
  logic [7:0] m_data;

  assign v1_in   = valid_in && !sel;
  assign v2_in   = valid_in && sel;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_valid = sel ? valid2 : valid1;
  assign m_sof   = sel ? sof2   : sof1;
  assign m_data  = sel ? d2     : d1;

  datapath_histogram #(.FRAME_LEN(24), .NUM_BINS(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .data_in(data_in), .valid_in(v1_in), .sof_in(sof_in),
    .busy_out(busy1), .data_out(d1), .valid_out(valid1), .sof_out(sof1), .busy_in(busy_in)
  );

  datapath_histogram #(.FRAME_LEN(300), .NUM_BINS(8), .CNT_W(16)) dut_long (
    .i_clk(clk), .i_rst(rst), .data_in(data_in), .valid_in(v2_in), .sof_in(sof_in),
    .busy_out(busy2), .data_out(d2), .valid_out(valid2), .sof_out(sof2), .busy_in(busy_in)
  );

  typedef struct {
    logic [7:0] pix [8];
    int         plen;
    int         pre_n;
    logic       stall;
    logic [7:0] exp [8];
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_cur [8];
  logic       stall_cur;
  int         checks = 0;
  int         failures = 0;
  int         pix_seq = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic drive_pix(input logic [7:0] d, input logic s);
    if ((pix_seq % 7) == 3) begin
      valid_in = 1'b0; data_in = 8'hE0; sof_in = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    pix_seq++;
    chk("in_ready", {31'b0, m_busy}, 32'd0);
    valid_in = 1'b1; data_in = d; sof_in = s;
    @(posedge clk); @(negedge clk);
    valid_in = 1'b0; sof_in = 1'b0; data_in = 8'h00;
  endtask

  task automatic collect();
    int beats = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic ps = 1'b0;
    logic pstall = 1'b0;
    logic [7:0] pd = 8'h00;
    chk("flush_busy", {31'b0, m_busy}, 32'd1);
    chk("flush_valid", {31'b0, m_valid}, 32'd0);
    while (beats < 8 && cyc < 300) begin
      busy_in = stall_cur ? (((cyc / 8) % 2) == 0) : 1'b0;
      if (cyc == 1) chk("first_bin_latency", {31'b0, m_valid}, 32'd1);
      if (pstall && pv) begin
        chk("hold_valid", {31'b0, m_valid}, 32'd1);
        chk("hold_data", {24'b0, m_data}, {24'b0, pd});
        chk("hold_sof", {31'b0, m_sof}, {31'b0, ps});
      end
      if (m_valid) chk("drain_busy", {31'b0, m_busy}, 32'd1);
      if (m_valid && !busy_in) begin
        chk("bin_data", {24'b0, m_data}, {24'b0, exp_cur[beats]});
        chk("bin_sof", {31'b0, m_sof}, (beats == 0) ? 32'd1 : 32'd0);
        beats++;
      end
      pv = m_valid; pd = m_data; ps = m_sof; pstall = busy_in;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    busy_in = 1'b0;
    chk("packet_complete", beats, 32'd8);
    chk("rearm_valid", {31'b0, m_valid}, 32'd0);
    chk("rearm_busy", {31'b0, m_busy}, 32'd0);
  endtask

  task automatic drive_frame(input int i);
    for (int p = 0; p < vecs[i].pre_n; p++) drive_pix(8'h00, 1'b0);
    for (int n = 0; n < 24; n++) drive_pix(vecs[i].pix[n % vecs[i].plen], n == 0);
  endtask

  task automatic run_vec(input int i);
    drive_frame(i);
    exp_cur   = vecs[i].exp;
    stall_cur = vecs[i].stall;
    collect();
  endtask

  initial begin
    vecs[0].pix = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[0].plen = 6; vecs[0].pre_n = 0; vecs[0].stall = 1'b0;
    vecs[0].exp = '{8'd12, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd12};
    vecs[1].pix = '{8'h1F, 8'h3F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].plen = 3; vecs[1].pre_n = 0; vecs[1].stall = 1'b0;
    vecs[1].exp = '{8'd8, 8'd8, 8'd0, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[2] = vecs[0];
    vecs[2].stall = 1'b1;
    vecs[3].pix = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].plen = 1; vecs[3].pre_n = 10; vecs[3].stall = 1'b0;
    vecs[3].exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd24};
    vecs[4].pix = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0};
    vecs[4].plen = 8; vecs[4].pre_n = 0; vecs[4].stall = 1'b1;
    vecs[4].exp = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    vecs[5].pix = '{8'h05, 8'hE5, 8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].plen = 3; vecs[5].pre_n = 0; vecs[5].stall = 1'b0;
    vecs[5].exp = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd8, 8'd0, 8'd0, 8'd8};

    rst = 1'b1; data_in = 8'h00; valid_in = 1'b0; sof_in = 1'b0; busy_in = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_valid", {31'b0, valid1}, 32'd0);
    chk("rst_sof", {31'b0, sof1}, 32'd0);
    chk("rst_data", {24'b0, d1}, 32'd0);
    chk("rst_long_busy", {31'b0, busy2}, 32'd0);
    chk("rst_long_valid", {31'b0, valid2}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset while the packet is draining, then a clean frame.
    drive_frame(1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    chk("pre_rst_busy", {31'b0, m_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("drain_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("drain_rst_busy", {31'b0, m_busy}, 32'd0);
    chk("drain_rst_sof", {31'b0, m_sof}, 32'd0);
    chk("drain_rst_data", {24'b0, m_data}, 32'd0);
    run_vec(1);

    // 300-pixel frame of zeros: bin 0 saturates on the 8-bit output.
    sel = 1'b1;
    for (int n = 0; n < 300; n++) drive_pix(8'h00, n == 0);
    exp_cur   = '{8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    stall_cur = 1'b0;
    collect();
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
